regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_if.sv | 27 ++
 rtl/regfile.sv | 57 +++++
 tb/tb_regfile.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file definitions (widths, bus types, control levels).
`default_nettype none
package regfile_pkg;

  localparam int RegisterNumLog2 = 5;
  localparam int RegisterNum     = 1 << RegisterNumLog2;
  localparam int RegisterWidth   = 32;

  typedef logic [RegisterWidth-1:0]   RegisterBus;
  typedef logic [RegisterNumLog2-1:0] RegisterAddressBus;

  localparam RegisterBus        ZeroWord           = '0;
  localparam RegisterAddressBus NOPRegisterAddress = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic ResetEnable  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/regfile_if.sv
// regfile_if: one write port and two read ports of the register file.
`default_nettype none
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface
`default_nettype wire

// File: rtl/regfile.sv
// regfile: 2**ADDR_W x DATA_W register file, r0 hardwired to zero, two combinational
// read ports with write-through bypass, synchronous active-high reset clearing the array.
`default_nettype none
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RegisterWidth,
  parameter int ADDR_W = RegisterNumLog2
) (
  input  wire logic  clk,
  input  wire logic  reset,
  regfile_if.slave   rf
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(NOPRegisterAddress);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(ZeroWord);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset == ResetEnable) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_ZERO;
      end
    end else if (rf.we == WriteEnable && rf.waddr != ADDR_ZERO) begin
      regs[rf.waddr] <= rf.wdata;
    end
  end

  // Same priority chain for both ports; waddr==0 never bypasses because raddr==0 wins first.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_v,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (rst_v == ResetEnable)                  return DATA_ZERO;
    else if (re == ReadDisable)                return DATA_ZERO;
    else if (raddr == ADDR_ZERO)               return DATA_ZERO;
    else if (we == WriteEnable && raddr == waddr) return wdata;
    else                                       return stored;
  endfunction

  always_comb begin
    rf.rdata1 = read_port(reset, rf.re1, rf.raddr1, rf.we, rf.waddr, rf.wdata, regs[rf.raddr1]);
  end

  always_comb begin
    rf.rdata2 = read_port(reset, rf.re2, rf.raddr2, rf.we, rf.waddr, rf.wdata, regs[rf.raddr2]);
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
// tb_regfile: directed and random stimulus, expectations queued and checked by a monitor.
`default_nettype none
module tb_regfile;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Architectural contents of the register file as the specification describes them.
  bit [31:0] model [32];

  function automatic bit [31:0] model_read(bit rst_v, bit re, bit [4:0] a,
                                           bit we, bit [4:0] wa, bit [31:0] wd);
    if (rst_v || !re || a == 0) return 32'h0;
    if (we && a == wa) return wd;
    return model[a];
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      total++;
      if (bus.rdata1 !== x.e1) begin
        bad++;
        $display("FAIL %s port1: got %h want %h", x.name, bus.rdata1, x.e1);
      end
      total++;
      if (bus.rdata2 !== x.e2) begin
        bad++;
        $display("FAIL %s port2: got %h want %h", x.name, bus.rdata2, x.e2);
      end
    end
  end

  // Drive one cycle, queue its expectation, then advance the model through the edge.
  task automatic step(input string name, input bit rst_v, input bit we, input bit [4:0] wa,
                      input bit [31:0] wd, input bit r1, input bit [4:0] a1,
                      input bit r2, input bit [4:0] a2,
                      input bit own, input bit [31:0] x1, input bit [31:0] x2);
    exp_t x;
    reset      = rst_v;
    bus.we     = we;
    bus.waddr  = wa;
    bus.wdata  = wd;
    bus.re1    = r1;
    bus.raddr1 = a1;
    bus.re2    = r2;
    bus.raddr2 = a2;
    x.name = name;
    if (own) begin
      x.e1 = x1;
      x.e2 = x2;
    end else begin
      x.e1 = model_read(rst_v, r1, a1, we, wa, wd);
      x.e2 = model_read(rst_v, r2, a2, we, wa, wd);
    end
    sb.push_back(x);
    @(posedge clk);
    if (rst_v) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  initial begin
    bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk);
    #1;

    step("reset_out", 1, 1, 5'd9, 32'h99, 1, 5'd9, 1, 5'd0, 1, 32'h0, 32'h0);
    step("reset_hold", 1, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd31, 1, 32'h0, 32'h0);

    step("wr_r5", 0, 1, 5'd5, 32'h12345678, 0, 5'd5, 0, 5'd5, 1, 32'h0, 32'h0);
    step("rd_r5", 0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5, 1, 32'h12345678, 32'h12345678);

    step("r0_write", 0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, 1, 32'h0, 32'h0);
    step("r0_after", 0, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0, 1, 32'h0, 32'h0);

    step("wr_r7", 0, 1, 5'd7, 32'h1, 1, 5'd5, 0, 5'd7, 1, 32'h12345678, 32'h0);
    step("bypass", 0, 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 1, 5'd7, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step("stale_waddr", 0, 0, 5'd7, 32'h5A5A5A5A, 1, 5'd7, 1, 5'd7, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);

    step("wr_r3", 0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 1, 32'h0, 32'h0);
    step("re2_off", 0, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3, 1, 32'hDEADBEEF, 32'h0);
    step("re2_on", 0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3, 1, 32'hDEADBEEF, 32'hDEADBEEF);

    for (int i = 1; i < 32; i++)
      step("fill", 0, 1, 5'(i), 32'(i), 1, 5'(i), 0, 5'd0, 1, 32'(i), 32'h0);
    step("fill_chk", 0, 0, 5'd0, 32'h0, 1, 5'd31, 1, 5'd9, 1, 32'd31, 32'd9);
    step("mid_reset", 1, 1, 5'd9, 32'h99, 1, 5'd9, 1, 5'd1, 1, 32'h0, 32'h0);
    for (int i = 1; i < 32; i += 2)
      step("post_reset", 0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i + 1 < 32 ? i + 1 : 9),
           1, 32'h0, 32'h0);

    for (int n = 0; n < 10000; n++) begin
      bit rr, we, r1, r2;
      bit [4:0] wa, a1, a2;
      bit [31:0] wd;
      rr = ($urandom_range(0, 99) == 0);
      we = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      r1 = $urandom_range(0, 7) != 0;
      r2 = $urandom_range(0, 7) != 0;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step("random", rr, we, wa, wd, r1, a1, r2, a2, 0, 32'h0, 32'h0);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
